// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin single-owner arbiter for the shared PE-to-PE data bus.
// Grants one eligible requester per cycle and drives registered bus, one-hot
// write-acknowledge and read-strobe outputs. Each granted PE is locked out for
// HOLDOFF cycles so a stale valid still in flight is never granted twice.
module bus_arbiter #(
    parameter int NUM_PE       = 8,
    parameter int DATA_LEN     = 16,
    parameter int BUS_ADDR_LEN = 3,
    parameter int NUM_STAGES   = 3,
    parameter int HOLDOFF      = 2*NUM_STAGES+1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUS_ADDR_LEN-1:0] addr_to_bus_p    [0:NUM_PE-1],
    input  logic [DATA_LEN-1:0]     data_to_bus_p    [0:NUM_PE-1],
    input  logic [NUM_PE-1:0]       valid_to_bus_p,
    input  logic [NUM_PE-1:0]       rd_buffer_full_p [0:NUM_PE-1],
    output logic [DATA_LEN-1:0]     data_bus,
    output logic [BUS_ADDR_LEN-1:0] addr_bus,
    output logic [NUM_PE-1:0]       wr_to_bus,
    output logic [NUM_PE-1:0]       rd_from_bus,
    output logic                    bus_err
);

    localparam int                HOLD_W    = $clog2(HOLDOFF+1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);
    // Eligibility vector is padded to the full address space so the rotating
    // scan index is exactly BUS_ADDR_LEN bits wide.
    localparam int                SPACE     = 1 << BUS_ADDR_LEN;

    if (HOLDOFF < 1 || NUM_STAGES < 1 || SPACE < NUM_PE) begin : g_bad_params
        $error("bus_arbiter: illegal parameter combination");
    end

    logic [BUS_ADDR_LEN-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0]       hold_q [NUM_PE];
    logic [HOLD_W-1:0]       hold_d [NUM_PE];
    logic [DATA_LEN-1:0]     data_q, data_d;
    logic [BUS_ADDR_LEN-1:0] addr_q, addr_d;
    logic [NUM_PE-1:0]       wr_q, wr_d;
    logic [NUM_PE-1:0]       rd_q, rd_d;
    logic                    err_q, err_d;

    logic [NUM_PE-1:0]       full_sel;
    logic [NUM_PE-1:0]       bad_dst;
    logic [SPACE-1:0]        elig;
    logic                    gnt;
    logic [BUS_ADDR_LEN-1:0] gnt_src;
    logic [BUS_ADDR_LEN-1:0] gnt_dst;
    logic [BUS_ADDR_LEN-1:0] scan_idx;

    // Per-PE eligibility: valid, out of holdoff, legal destination, destination not full.
    always_comb begin
        full_sel = '0;
        bad_dst  = '0;
        elig     = '0;
        for (int s = 0; s < NUM_PE; s++) begin
            // Select the full flag without ever indexing past the last PE.
            for (int d = 0; d < NUM_PE; d++) begin
                if (int'(addr_to_bus_p[s]) == d) begin
                    full_sel[s] = rd_buffer_full_p[d][s];
                end
            end
            bad_dst[s] = valid_to_bus_p[s] && (int'(addr_to_bus_p[s]) >= NUM_PE);
            elig[s]    = valid_to_bus_p[s] && (hold_q[s] == '0) &&
                         (int'(addr_to_bus_p[s]) < NUM_PE) && !full_sel[s];
        end
    end

    // Rotating scan from ptr; descending order lets the nearest eligible PE win.
    always_comb begin
        gnt      = 1'b0;
        gnt_src  = '0;
        scan_idx = '0;
        for (int k = NUM_PE-1; k >= 0; k--) begin
            scan_idx = BUS_ADDR_LEN'((int'(ptr_q) + k) % NUM_PE);
            if (elig[scan_idx]) begin
                gnt     = 1'b1;
                gnt_src = scan_idx;
            end
        end
    end

    // Next-state for pointer, holdoff counters, bus outputs and error flag.
    always_comb begin
        gnt_dst = addr_to_bus_p[gnt_src];
        ptr_d   = ptr_q;
        data_d  = data_q;
        addr_d  = addr_q;
        wr_d    = '0;
        rd_d    = '0;
        err_d   = err_q | (|bad_dst);
        for (int s = 0; s < NUM_PE; s++) begin
            hold_d[s] = (hold_q[s] != '0) ? hold_q[s] - 1'b1 : '0;
            if (gnt && (gnt_src == BUS_ADDR_LEN'(s))) begin
                hold_d[s] = HOLD_LOAD;
            end
        end
        if (gnt) begin
            data_d = data_to_bus_p[gnt_src];
            addr_d = gnt_src;
            wr_d   = NUM_PE'(1) << gnt_src;
            rd_d   = NUM_PE'(1) << gnt_dst;
            ptr_d  = (int'(gnt_src) == NUM_PE-1) ? '0 : gnt_src + 1'b1;
        end
    end

    // State and output registers; reset discards any grant decided this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            data_q <= '0;
            addr_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
            for (int s = 0; s < NUM_PE; s++) begin
                hold_q[s] <= '0;
            end
        end else begin
            ptr_q  <= ptr_d;
            data_q <= data_d;
            addr_q <= addr_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            err_q  <= err_d;
            for (int s = 0; s < NUM_PE; s++) begin
                hold_q[s] <= hold_d[s];
            end
        end
    end

    assign data_bus    = data_q;
    assign addr_bus    = addr_q;
    assign wr_to_bus   = wr_q;
    assign rd_from_bus = rd_q;
    assign bus_err     = err_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Single-owner arbiter for the shared PE-to-PE data bus. It takes the pipelined per-PE write requests and receive-buffer full flags and grants one PE per cycle, round-robin. It then drives the shared data/address bus together with one-hot write-acknowledge and read-strobe vectors, which the bus pipeline carries back out to the PEs. The block compensates for pipeline round-trip latency by locking out each granted PE for a fixed holdoff window, so a stale `valid` is never granted twice.

## Interface
- `NUM_PE`, 8, number of processing elements on the bus.
- `DATA_LEN`, 16, bus data width.
- `BUS_ADDR_LEN`, 3, PE index width; must satisfy 2^BUS_ADDR_LEN >= NUM_PE.
- `NUM_STAGES`, 3, pipeline depth on each leg between PEs and arbiter.
- `HOLDOFF`, 2*NUM_STAGES+1, cycles a granted PE is ineligible after its grant; minimum 1.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `addr_to_bus_p[0:NUM_PE-1]`  in  BUS_ADDR_LEN each  destination PE index of each requester.
- `data_to_bus_p[0:NUM_PE-1]`  in  DATA_LEN each  payload of each requester.
- `valid_to_bus_p`  in  NUM_PE  request valid, bit s = PE s.
- `rd_buffer_full_p[0:NUM_PE-1]`  in  NUM_PE each  bit [d][s] = destination d cannot accept from source s.
- `data_bus`  out  DATA_LEN  granted payload.
- `addr_bus`  out  BUS_ADDR_LEN  source PE index of the granted transfer.
- `wr_to_bus`  out  NUM_PE  one-hot grant/acknowledge to the source PE.
- `rd_from_bus`  out  NUM_PE  one-hot read strobe to the destination PE.
- `bus_err`  out  1  sticky flag: a valid request carried destination >= NUM_PE.

## Operation
- State:
  - round-robin pointer `ptr`, range 0..NUM_PE-1;
  - per-PE holdoff counter `hold[s]`, width $clog2(HOLDOFF+1);
  - output registers.
- PE s is eligible when all of the following hold:
  - `valid_to_bus_p[s]`;
  - `hold[s]==0`;
  - `addr_to_bus_p[s] < NUM_PE`;
  - `!rd_buffer_full_p[addr_to_bus_p[s]][s]`.
  - Self-addressing (destination == s) is legal.
- Arbitration: the first eligible PE scanning s = ptr, ptr+1, …, wrapping mod NUM_PE is granted. At most one grant per cycle.
- On grant to s with destination d:
  - register `data_bus`=data_to_bus_p[s], `addr_bus`=s;
  - register `wr_to_bus`=1<<s and `rd_from_bus`=1<<d;
  - set `hold[s]`=HOLDOFF;
  - set `ptr`=(s+1) mod NUM_PE.
- No grant: `wr_to_bus` and `rd_from_bus` register 0; `data_bus`/`addr_bus` hold their last values; `ptr` is unchanged.
- Each nonzero `hold[s]` decrements by 1 per cycle. The load on grant takes precedence; a PE in holdoff cannot be granted, so load and decrement never collide.
- A valid request with an out-of-range destination is never granted and sets `bus_err`. `bus_err` clears only on `rst`.
- Source protocol (PE side, required for correctness): a PE holds valid/addr/data stable until it sees its `wr_to_bus` bit, then drops valid or presents the next word.
- Destination protocol: full flags reach the arbiter 2*NUM_STAGES late, so each receive buffer keeps at least 2*NUM_STAGES+1 free slots of margin when it deasserts full.

## Timing
- Reset (`rst` sampled high at a clk edge):
  - outputs next cycle: `data_bus`=0, `addr_bus`=0, `wr_to_bus`=0, `rd_from_bus`=0, `bus_err`=0;
  - internal: `ptr`=0, all `hold`=0.
- Reset mid-operation: any grant decided in the same cycle is discarded and no strobe issues.
- Latency: inputs sampled at edge t drive outputs valid after edge t+1, i.e. one registered stage.
- `wr_to_bus` and `rd_from_bus` are single-cycle pulses, always both zero or both exactly one-hot, in the same cycle.
- Throughput: one transfer per cycle when distinct PEs are eligible. A single PE streaming alone gets one grant per HOLDOFF+1 cycles.
- Round trip seen by a PE: request → ack arrives 2*NUM_STAGES+1 cycles after valid is first presented at the PE. HOLDOFF covers the stale-valid window.

## Test plan
NUM_PE=4, NUM_STAGES=1, HOLDOFF=3 unless stated.
1. Reset: hold `rst` high 2 cycles with all valids high → all outputs 0 throughout and on the first cycle after release; first grant goes to PE0.
2. Round-robin: all four PEs valid, destinations 3,2,1,0, no full flags → `wr_to_bus` = 0001, 0010, 0100, 1000, then 0001 again. `rd_from_bus` = 1000, 0100, 0010, 0001. `addr_bus` = 0,1,2,3.
3. Holdoff: only PE2 valid continuously with data 0xA5A5 → grants on cycles 1, 5, 9 (every 4 cycles); `hold[2]` reads 3,2,1,0 between grants.
4. Full blocking: PE0→PE1 with `rd_buffer_full_p[1][0]`=1, PE3→PE1 not full → PE3 granted, PE0 never granted. Deasserting the full bit → PE0 granted the next eligible cycle.
5. Bad address: NUM_PE=3, BUS_ADDR_LEN=2, PE1 valid with destination 3 → no grant to PE1; `bus_err`=1 next cycle and stays 1 until `rst`.
6. Reset mid-stream: assert `rst` in the cycle PE1 would be granted → no `wr_to_bus`/`rd_from_bus` pulse; `ptr`=0 and all holdoffs cleared after reset.
